vga_scene_sequencer: RTL and testbench
======================================

// Module: vga_scene_sequencer
// PURPOSE
// Scene controller for the VGA pattern demo. Chooses which pattern, y-mode and time-mode
// configuration drives the Worley/sine datapath, from debounced next/prev buttons or an auto timer.
// Changes are applied only on frame boundaries, so a frame never tears.
// Each change can be followed by optional blank frames. Sits between ui_in and test_hvsync_top.
// PARAMETERS
// NUM_SCENES       8     scene count, 2..16
// SCENE_TABLE      {8'h06,8'h05,...}  packed NUM_SCENES x 8b; entry k = bits [8k+7:8k] = {timemode[1:0],inymode[2:0],patmode[2:0]}
// DEBOUNCE_CYCLES  16'd50000  clocks a synced button level must stay stable before it is accepted, >=1
// HOLD_FRAMES      10'd300   frames per scene in auto mode, >=1
// BLANK_FRAMES     4'd2      blanked frames after each scene change, 0 = no blanking
// PORTS
// clk          in   1  pixel clock
// rst_n        in   1  asynchronous active-low reset
// frame_start  in   1  one-cycle pulse at hpos==0 && vpos==0, from hvsync_generator
// btn_next     in   1  raw asynchronous button, active high
// btn_prev     in   1  raw asynchronous button, active high
// auto_en      in   1  level; 1 = auto-advance every HOLD_FRAMES frames
// scene_idx    out  4  current scene index
// patmode      out  3  registered config field
// inymode      out  3  registered config field
// timemode     out  2  registered config field
// blank        out  1  1 = datapath must output black (AND into display_on)
// scene_change out  1  one-cycle pulse on load; drives sine_wave_generator reset and tm clear
// BEHAVIOUR
// Reset (async, all flops):
//   scene_idx=0, {timemode,inymode,patmode}=SCENE_TABLE[7:0], blank=0, scene_change=0
//   state=SHOW, frame timer=0, blank counter=0, debouncers stable=0 with counters cleared
// Debounce, per button:
//   - 2-flop synchronizer, then counter; counter clears while synced==stable
//   - stable<=synced when the counter reaches DEBOUNCE_CYCLES-1
//   - press = rising edge of stable, a 1-cycle pulse; release produces nothing
//   - press latency = DEBOUNCE_CYCLES+2 clocks after a clean input edge
// Request decode, same cycle as the press pulses:
//   - next press only -> req=+1; prev press only -> req=-1; both in one cycle -> no request
//   - auto: while state==SHOW && auto_en, count frame_start pulses
//   - auto: when the count reaches HOLD_FRAMES-1 and frame_start is high -> req=+1
//   - auto: a button request in the same cycle wins; the auto request is dropped
//   - auto_en=0 freezes the timer at its value, it does not clear
// FSM states SHOW, ARMED, BLANK:
//   - SHOW: a request latches its direction into dir and goes ARMED
//   - ARMED: further requests are ignored; wait for frame_start
//   - ARMED + frame_start, same edge:
//       scene_idx <= idx+dir, wrapping NUM_SCENES-1 -> 0 and 0 -> NUM_SCENES-1
//       config fields <= SCENE_TABLE[new idx]
//       scene_change=1 for exactly this one cycle
//       frame timer <= 0
//       if BLANK_FRAMES>0: blank<=1, blank counter<=0, state BLANK; else state SHOW
//   - BLANK: requests are ignored; each frame_start increments the blank counter
//   - BLANK exit: at the frame_start where the counter == BLANK_FRAMES-1, blank<=0, state SHOW
//   - result: exactly BLANK_FRAMES whole frames are blanked
// Outputs:
//   - all outputs registered; config never changes except in the frame_start cycle
//   - a request and frame_start in the same SHOW cycle only arms; the load happens at the next frame_start
// TESTING (bench params: NUM_SCENES=4, DEBOUNCE_CYCLES=4, HOLD_FRAMES=3, BLANK_FRAMES=1, frame_start every 20 clk)
// T1 reset with rst_n=0 mid-frame, then release -> scene_idx=0, cfg=entry0, blank=0; async clear checked with no clk edge
// T2 btn_next bounce 1-0-1 at 1-clk spacing, then held 10 clk, auto_en=0
//    -> exactly one press; at next frame_start scene_idx=1, scene_change one cycle, blank=1 for 1 frame
// T3 btn_prev pressed at scene 0 -> scene_idx=3 with cfg=entry3; then 4 next presses,
//    each waiting out BLANK -> idx sequence 0,1,2,3
// T4 auto_en=1, no buttons -> scene advances every 3 SHOW frames plus 1 blank frame (0->1->2->3->0);
//    auto_en dropped for 5 frames -> timer holds, then resumes from held count
// T5 btn_next and btn_prev debounced in the same cycle -> no change;
//    next pressed during BLANK -> ignored, scene_idx unchanged
// T6 rst_n asserted while ARMED and while BLANK -> immediately idx=0, blank=0, no scene_change pulse after release

Source files
------------

// File: rtl/vga_scene_sequencer.sv
// Scene selector for the VGA pattern demo: debounced next/prev buttons or an auto
// timer request a scene change, which is applied on a frame boundary and optionally followed by blank frames.

module vga_scene_btn_db #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);
  logic [1:0]  r_sync;
  logic        r_stable;
  logic        r_press;
  logic [15:0] r_cnt;
  logic        w_synced;

  assign w_synced = r_sync[1];
  assign o_press  = r_press;

  // The press pulse is registered together with the stable flip so it lines up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        r_stable <= w_synced;
        r_press  <= w_synced;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end
endmodule

module vga_scene_sequencer #(
  parameter int                      NUM_SCENES      = 8,
  parameter logic [NUM_SCENES*8-1:0] SCENE_TABLE     = {8'h06, 8'h05, 8'h4C, 8'h8B,
                                                        8'h13, 8'h52, 8'h09, 8'hC8},
  parameter logic [15:0]             DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [9:0]              HOLD_FRAMES     = 10'd300,
  parameter logic [3:0]              BLANK_FRAMES    = 4'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  output logic [3:0] scene_idx,
  output logic [2:0] patmode,
  output logic [2:0] inymode,
  output logic [1:0] timemode,
  output logic       blank,
  output logic       scene_change
);
  typedef enum logic [1:0] {S_SHOW, S_ARMED, S_BLANK} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_dir, w_dir_nxt;
  logic [9:0]  r_timer, w_timer_nxt;
  logic [3:0]  r_bcnt, w_bcnt_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_cfg, w_cfg_nxt;
  logic        r_blank, w_blank_nxt;
  logic        r_chg, w_chg_nxt;

  logic [1:0]  w_btn, w_press;
  logic        w_req_up, w_req_dn, w_auto, w_req;
  logic [3:0]  w_idx_up, w_idx_dn, w_idx_load;
  logic [7:0]  w_tbl [16];

  assign w_btn = {btn_prev, btn_next};

  for (genvar g = 0; g < 2; g++) begin : g_db
    vga_scene_btn_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (w_btn[g]),
      .o_press(w_press[g])
    );
  end

  // Pad the table to 16 entries so a 4-bit index is always in range.
  for (genvar k = 0; k < 16; k++) begin : g_tbl
    if (k < NUM_SCENES) begin : g_use
      assign w_tbl[k] = SCENE_TABLE[8*k +: 8];
    end else begin : g_pad
      assign w_tbl[k] = 8'h00;
    end
  end

  // Simultaneous presses cancel; any button request suppresses the auto request.
  assign w_req_up = w_press[0] & ~w_press[1];
  assign w_req_dn = w_press[1] & ~w_press[0];
  assign w_auto   = auto_en & frame_start & (r_timer == HOLD_FRAMES - 10'd1);
  assign w_req    = w_req_up | w_req_dn | w_auto;

  assign w_idx_up   = (r_idx == 4'(NUM_SCENES - 1)) ? 4'd0 : r_idx + 4'd1;
  assign w_idx_dn   = (r_idx == 4'd0) ? 4'(NUM_SCENES - 1) : r_idx - 4'd1;
  assign w_idx_load = r_dir ? w_idx_dn : w_idx_up;

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_bcnt_nxt  = r_bcnt;
    w_idx_nxt   = r_idx;
    w_cfg_nxt   = r_cfg;
    w_blank_nxt = r_blank;
    w_chg_nxt   = 1'b0;
    case (r_state)
      S_SHOW: begin
        if (auto_en && frame_start && (r_timer != HOLD_FRAMES - 10'd1))
          w_timer_nxt = r_timer + 10'd1;
        if (w_req) begin
          w_state_nxt = S_ARMED;
          w_dir_nxt   = w_req_dn;
        end
      end
      S_ARMED: begin
        if (frame_start) begin
          w_idx_nxt   = w_idx_load;
          w_cfg_nxt   = w_tbl[w_idx_load];
          w_chg_nxt   = 1'b1;
          w_timer_nxt = '0;
          if (BLANK_FRAMES != 4'd0) begin
            w_blank_nxt = 1'b1;
            w_bcnt_nxt  = '0;
            w_state_nxt = S_BLANK;
          end else begin
            w_state_nxt = S_SHOW;
          end
        end
      end
      S_BLANK: begin
        if (frame_start) begin
          if (r_bcnt == BLANK_FRAMES - 4'd1) begin
            w_blank_nxt = 1'b0;
            w_state_nxt = S_SHOW;
          end else begin
            w_bcnt_nxt = r_bcnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_SHOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SHOW;
      r_dir   <= 1'b0;
      r_timer <= '0;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_cfg   <= SCENE_TABLE[7:0];
      r_blank <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_timer <= w_timer_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_idx   <= w_idx_nxt;
      r_cfg   <= w_cfg_nxt;
      r_blank <= w_blank_nxt;
      r_chg   <= w_chg_nxt;
    end
  end

  assign scene_idx    = r_idx;
  assign patmode      = r_cfg[2:0];
  assign inymode      = r_cfg[5:3];
  assign timemode     = r_cfg[7:6];
  assign blank        = r_blank;
  assign scene_change = r_chg;
endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Bench for vga_scene_sequencer: a frame-level scene model checked every cycle,
// plus literal expectations at key points of each directed scenario.

module tb_vga_scene_sequencer;
  localparam int N    = 4;
  localparam int D    = 4;
  localparam int HOLD = 3;
  localparam int NBLK = 1;

  logic clk = 0, rst_n = 1, frame_start = 0, btn_next = 0, btn_prev = 0, auto_en = 0;
  logic [3:0] scene_idx;
  logic [2:0] patmode, inymode;
  logic [1:0] timemode;
  logic blank, scene_change;

  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [7:0] cfg_of [4] = '{8'h06, 8'h51, 8'h8A, 8'hC5};

  vga_scene_sequencer #(
    .NUM_SCENES(4), .SCENE_TABLE(32'hC58A5106), .DEBOUNCE_CYCLES(16'd4),
    .HOLD_FRAMES(10'd3), .BLANK_FRAMES(4'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .btn_next(btn_next),
    .btn_prev(btn_prev), .auto_en(auto_en), .scene_idx(scene_idx), .patmode(patmode),
    .inymode(inymode), .timemode(timemode), .blank(blank), .scene_change(scene_change)
  );

  always #5 clk = ~clk;

  int fcnt = 0;
  always @(negedge clk) begin
    frame_start = (fcnt == 19);
    fcnt = (fcnt == 19) ? 0 : fcnt + 1;
  end

  // Model: a button counts as pressed once its raw samples (seen through two
  // sync stages) have held a new level for D consecutive clocks.
  logic [15:0] hn = '0, hp = '0;
  bit sn, sp, m_chg, m_blank, m_pend, m_dir;
  int m_idx, m_left, m_shown;

  function automatic bit settled(input logic [15:0] h, input bit v);
    bit ok = 1;
    for (int k = 2; k <= D + 1; k++) if (h[k] !== v) ok = 0;
    return ok;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit pn, pp, btn_req, do_auto;
    if (!rst_n) begin
      hn = '0; hp = '0; sn = 0; sp = 0;
      m_idx = 0; m_chg = 0; m_blank = 0; m_pend = 0; m_dir = 0; m_left = 0; m_shown = 0;
    end else begin
      pn = 0; pp = 0;
      if (!sn && settled(hn, 1)) begin sn = 1; pn = 1; end
      else if (sn && settled(hn, 0)) sn = 0;
      if (!sp && settled(hp, 1)) begin sp = 1; pp = 1; end
      else if (sp && settled(hp, 0)) sp = 0;
      hn = {hn[14:0], btn_next};
      hp = {hp[14:0], btn_prev};
      btn_req = pn ^ pp;
      m_chg = 0;
      if (m_pend) begin
        if (frame_start) begin
          m_idx = (m_idx + N + (m_dir ? -1 : 1)) % N;
          m_chg = 1; m_shown = 0; m_pend = 0;
          if (NBLK > 0) begin m_blank = 1; m_left = NBLK; end
        end
      end else if (m_left != 0) begin
        if (frame_start) begin
          m_left--;
          if (m_left == 0) m_blank = 0;
        end
      end else begin
        do_auto = auto_en && frame_start && (m_shown == HOLD - 1);
        if (auto_en && frame_start && m_shown < HOLD - 1) m_shown++;
        if (btn_req) begin m_pend = 1; m_dir = pp; end
        else if (do_auto) begin m_pend = 1; m_dir = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (scene_idx !== 4'(m_idx) || {timemode, inymode, patmode} !== cfg_of[m_idx] ||
          blank !== m_blank || scene_change !== m_chg) begin
        errors++;
        $display("FAIL model t=%0t idx got %0d exp %0d cfg got %h exp %h blank got %b exp %b chg got %b exp %b",
                 $time, scene_idx, m_idx, {timemode, inymode, patmode}, cfg_of[m_idx],
                 blank, m_blank, scene_change, m_chg);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic wait_fs(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      do begin @(posedge clk); t++; end while (!frame_start && t < 50);
      if (!frame_start) begin
        checks++; errors++;
        $display("FAIL wait_fs got no frame_start exp one within 50 clk");
      end
    end
    #1;
  endtask

  task automatic wait_chg();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      seen = scene_change;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_chg got no scene_change exp one pulse");
    end
  endtask

  task automatic press(input bit nxt, input bit prv);
    @(negedge clk); btn_next = nxt; btn_prev = prv;
    repeat (8) @(negedge clk);
    btn_next = 0; btn_prev = 0;
    repeat (8) @(negedge clk);
  endtask

  // Press next right after a frame boundary so it arms before the next one, then wait for the load.
  task automatic press_and_load();
    wait_fs(1);
    @(negedge clk); btn_next = 1;
    repeat (10) @(negedge clk);
    btn_next = 0;
    wait_chg();
  endtask

  initial begin
    #1 rst_n = 0; chk_en = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // T1: async reset mid-frame, observed with no clock edge
    repeat (7) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t1_idx", scene_idx, 0);
    chk("t1_cfg", {timemode, inymode, patmode}, 8'h06);
    chk("t1_blank", blank, 0);
    chk("t1_chg", scene_change, 0);
    @(negedge clk); rst_n = 1;

    // T2: bouncing next press, held
    wait_fs(1);
    @(negedge clk); btn_next = 1;
    @(negedge clk); btn_next = 0;
    @(negedge clk); btn_next = 1;
    repeat (10) @(negedge clk);
    wait_chg();
    chk("t2_idx", scene_idx, 1);
    chk("t2_cfg", {timemode, inymode, patmode}, 8'h51);
    chk("t2_blank_on", blank, 1);
    @(negedge clk); btn_next = 0;
    @(posedge clk); #1;
    chk("t2_chg_one_cycle", scene_change, 0);
    wait_fs(1);
    chk("t2_blank_off", blank, 0);
    wait_fs(2);

    // T3: prev wraps 0 -> 3, then next walks 0..3
    press(0, 1); wait_fs(3);
    chk("t3_prev_to0", scene_idx, 0);
    press(0, 1); wait_fs(3);
    chk("t3_wrap_idx", scene_idx, 3);
    chk("t3_wrap_cfg", {timemode, inymode, patmode}, 8'hC5);
    for (int i = 0; i < 4; i++) begin
      press(1, 0); wait_fs(3);
      chk("t3_next_seq", scene_idx, i);
    end

    // T4: auto advance, then frozen timer
    auto_en = 1;
    wait_fs(4);
    chk("t4_auto0_idx", scene_idx, 0);
    chk("t4_auto0_blank", blank, 1);
    wait_fs(5); chk("t4_auto1", scene_idx, 1);
    wait_fs(5); chk("t4_auto2", scene_idx, 2);
    wait_fs(5); chk("t4_auto3", scene_idx, 3);
    wait_fs(2);
    auto_en = 0;
    wait_fs(5); chk("t4_frozen", scene_idx, 3);
    auto_en = 1;
    wait_fs(2); chk("t4_resume_armed", scene_idx, 3);
    wait_fs(1);
    chk("t4_resume_load", scene_idx, 0);
    chk("t4_resume_chg", scene_change, 1);
    auto_en = 0;
    wait_fs(1);

    // T5: simultaneous presses cancel; press during blank ignored
    press(1, 1); wait_fs(3);
    chk("t5_both", scene_idx, 0);
    press_and_load();
    chk("t5_load", scene_idx, 1);
    press(1, 0); wait_fs(3);
    chk("t5_blank_ignored", scene_idx, 1);

    // T6: reset while ARMED, then while BLANK
    wait_fs(1);
    @(negedge clk); btn_next = 1;
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_armed_idx", scene_idx, 0);
    chk("t6_armed_chg", scene_change, 0);
    btn_next = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    wait_fs(2);
    chk("t6_armed_after", scene_idx, 0);
    press_and_load();
    chk("t6_blank_pre", blank, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_blank_idx", scene_idx, 0);
    chk("t6_blank_off", blank, 0);
    @(negedge clk); rst_n = 1;
    wait_fs(2);
    chk("t6_blank_after", scene_idx, 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
